// File: rtl/shift_iter_if.sv
// rtl/shift_iter_if.sv - request/result handshake bundle for the iterative shifter
interface shift_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_iter.sv
// rtl/shift_iter.sv - 16-bit shifter reusing one level at distances 1, 2, 4, 8 over four cycles
module shift_iter (
    input  logic       clk,
    input  logic       rst,
    shift_iter_if.slave bus,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] acc;
    logic [3:0]  cnt_r;
    logic [1:0]  op_r;
    logic [1:0]  stg;
    logic        ready;
    logic        accept;

    // One shifter level: distance is 2^s, sign fill taken from v as it stands now.
    function automatic logic [15:0] shift_level(input logic [15:0] v,
                                                input logic [1:0]  op,
                                                input logic [1:0]  s);
        logic [31:0]        dbl;
        logic signed [15:0] sv;
        logic [4:0]         d;
        logic [15:0]        r;
        d   = 5'd1 << s;
        sv  = v;
        dbl = {v, v} << d;
        case (op)
            OP_ROL:  r = dbl[31:16];
            OP_SLL:  r = v << d;
            OP_SRA:  r = sv >>> d;
            OP_SRL:  r = v >> d;
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (stg == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A new request can ride on the same edge that drains the result.
                ready = bus.out_ready;
                if (bus.out_ready) begin
                    state_nxt = bus.in_valid ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = bus.in_valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 16'h0000;
            cnt_r <= 4'd0;
            op_r  <= 2'b00;
            stg   <= 2'd0;
        end else if (accept) begin
            acc   <= bus.in_data;
            cnt_r <= bus.in_cnt;
            op_r  <= bus.in_op;
            stg   <= 2'd0;
        end else if (state == SHIFT) begin
            if (cnt_r[stg]) begin
                acc <= shift_level(acc, op_r, stg);
            end
            stg <= stg + 2'd1;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign busy          = (state == SHIFT);
endmodule

// File: tb/tb_shift_iter.sv
// tb/tb_shift_iter.sv - scoreboard bench for shift_iter
module tb_shift_iter;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    shift_iter_if bus();

    shift_iter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int checks = 0;
    int errs   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Whole-distance reference, computed in one step rather than by levels.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                              input logic [1:0] op);
        logic signed [15:0] s;
        s = d;
        case (op)
            2'b00:   return (c == 4'd0) ? d : ((d << c) | (d >> (32'd16 - 32'(c))));
            2'b01:   return d << c;
            2'b10:   return 16'(s >>> c);
            default: return d >> c;
        endcase
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_result: got 0x%04h expected no result", bus.out_data);
                end else begin
                    check("result", bus.out_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                        input logic [15:0] exp, input bit rnd);
        bit ok;
        ok = 1'b0;
        bus.in_data  = d;
        bus.in_cnt   = c;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rnd) bus.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Status is {busy, in_ready, out_valid}: four SHIFT cycles, then the result.
    task automatic expect_timing(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check({name, "_shift_status"}, 16'({busy, bus.in_ready, bus.out_valid}), 16'(3'b100));
        end
        @(negedge clk);
        check({name, "_done_status"}, 16'({busy, bus.in_ready, bus.out_valid}),
              16'({1'b0, bus.out_ready, 1'b1}));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within 50 cycles");
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_cnt    = 4'd0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 16'(bus.in_ready), 16'h1);
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_out_data", bus.out_data, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        send(16'hF00F, 4'd4, 2'b00, 16'h00FF, 1'b0);  expect_timing("rol_f00f_4");
        send(16'h00FF, 4'd4, 2'b01, 16'h0FF0, 1'b0);  expect_timing("sll_00ff_4");
        send(16'h8000, 4'd15, 2'b11, 16'h0001, 1'b0); expect_timing("srl_8000_15");
        send(16'hFFFF, 4'd15, 2'b01, 16'h8000, 1'b0); expect_timing("sll_ffff_15");
        send(16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0); expect_timing("sra_8000_15");
        send(16'h7FF0, 4'd4, 2'b10, 16'h07FF, 1'b0);  expect_timing("sra_7ff0_4");
        send(16'h8001, 4'd1, 2'b00, 16'h0003, 1'b0);  expect_timing("rol_8001_1");
        for (int op = 0; op < 4; op++) begin
            send(16'hA5C3, 4'd0, 2'(op), 16'hA5C3, 1'b0);
            expect_timing("cnt0");
        end

        bus.out_ready = 1'b0;
        send(16'h1234, 4'd3, 2'b01, 16'h91A0, 1'b0);
        wait_valid();
        fork
            send(16'h00F0, 4'd4, 2'b11, 16'h000F, 1'b0);
            begin
                for (int i = 0; i < 6; i++) begin
                    check("bp_out_data", bus.out_data, 16'h91A0);
                    check("bp_in_ready", 16'(bus.in_ready), 16'h0);
                    check("bp_out_valid", 16'(bus.out_valid), 16'h1);
                    if (i < 5) @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        expect_timing("bp_next");

        send(16'hBEEF, 4'd5, 2'b00, 16'hDDF7, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", 16'(bus.in_ready), 16'h1);
        check("midrst_out_valid", 16'(bus.out_valid), 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_out_data", bus.out_data, 16'h0000);
        @(posedge clk);
        #1;
        send(16'h1234, 4'd8, 2'b00, 16'h3412, 1'b0);
        expect_timing("after_rst");

        for (int n = 0; n < 300; n++) begin
            logic [15:0] d;
            logic [3:0]  c;
            logic [1:0]  op;
            d  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            send(d, c, op, ref_shift(d, c, op), 1'b1);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
